// File: rtl/math_product_accumulator.sv
// Sequential multiply-accumulate back end: sums a programmed number of unsigned products.
// Define MATH_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module math_product_accumulator #(
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 2 * N + 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_count,
    input  logic               i_prod_valid,
    output logic               o_prod_ready,
    input  logic [2*N-1:0]     i_product,
    output logic               o_result_valid,
    input  logic               i_result_ready,
    output logic [ACC_W-1:0]   o_result,
    output logic               o_overflow,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_term_cnt
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;

    logic [ACC_W:0]     prod_ext;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   acc_next;

    assign prod_ext = (ACC_W + 1)'(i_product);
    assign sum      = {1'b0, acc_q} + prod_ext;

`ifdef MATH_ACC_SATURATE_EN
    // Once clamped, stay clamped for the remainder of the run.
    assign acc_next = (sum[ACC_W] || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        term_cnt_d  = term_cnt_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    acc_d      = '0;
                    ovf_d      = 1'b0;
                    term_cnt_d = '0;
                    if (i_count != '0) begin
                        remaining_d = i_count;
                        state_d     = StAccum;
                    end else begin
                        result_d = '0;
                        state_d  = StDone;
                    end
                end
            end
            StAccum: begin
                // Ready is high throughout this state, so valid alone marks a handshake.
                if (i_prod_valid) begin
                    acc_d       = acc_next;
                    ovf_d       = ovf_q | sum[ACC_W];
                    term_cnt_d  = term_cnt_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        result_d = acc_next;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (i_result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            term_cnt_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            term_cnt_q  <= term_cnt_d;
            remaining_q <= remaining_d;
        end
    end

    assign o_prod_ready   = (state_q == StAccum);
    assign o_result_valid = (state_q == StDone);
    assign o_busy         = (state_q != StIdle);
    assign o_result       = result_q;
    assign o_overflow     = ovf_q;
    assign o_term_cnt     = term_cnt_q;

endmodule

// File: doc/math_product_accumulator.md
Name: math_product_accumulator

Overview:
- Sequential multiply-accumulate back end. Sits directly downstream of the combinational carry-save array multiplier and consumes its 2*N-bit products.
- Sums a programmable number of products into a wide accumulator, with valid/ready handshakes on input and output.
- Used for dot-product and FIR-style reductions in the math library.

Parameters:
- N, 4, multiplier operand width; product input is 2*N bits.
- ACC_W, 2*N+8, accumulator and result width; must be >= 2*N.
- CNT_W, 8, width of the term-count field; max terms 2^CNT_W-1.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request a new accumulation; sampled only in IDLE.
- i_count  input  CNT_W  number of products to sum; sampled with i_start.
- i_prod_valid  input  1  product on i_product is valid.
- o_prod_ready  output  1  block accepts a product this cycle.
- i_product  input  2*N  unsigned product from the multiplier.
- o_result_valid  output  1  o_result holds the final sum.
- i_result_ready  input  1  downstream consumes the result.
- o_result  output  ACC_W  accumulated sum.
- o_overflow  output  1  sticky: accumulation exceeded ACC_W bits.
- o_busy  output  1  state is not IDLE.
- o_term_cnt  output  CNT_W  products accepted so far in the current run.

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset (async assert, sync release):
  - State goes to IDLE.
  - Accumulator, o_result, o_term_cnt and the remaining-term counter all go to 0.
  - o_prod_ready, o_result_valid, o_overflow and o_busy go to 0.
  - Reset mid-run discards any partial sum; no result is emitted.
- States: IDLE, ACCUM, DONE. All outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE:
  - o_prod_ready=0.
  - On i_start=1 with i_count>0: load remaining=i_count, clear acc, o_term_cnt and o_overflow, then go to ACCUM.
  - On i_start=1 with i_count==0: clear acc and o_overflow, o_result=0, then go to DONE.
- ACCUM:
  - o_prod_ready=1.
  - On a handshake (i_prod_valid & o_prod_ready):
    - acc <= acc + zero-extend(i_product).
    - o_term_cnt increments.
    - remaining decrements.
  - No handshake means no change; valid may drop between terms.
  - On the handshake with remaining==1: latch the final sum into o_result and go to DONE. o_result_valid asserts the cycle after the last handshake (1-cycle latency).
- DONE:
  - o_result_valid=1 and o_prod_ready=0.
  - o_result and o_overflow are held stable until i_result_ready=1. Then go to IDLE and drop o_result_valid in the same edge.
- Arithmetic: unsigned, computed at ACC_W+1 bits. Carry-out bit ACC_W sets o_overflow (sticky for the run). The stored value is per the optional feature.
- i_start outside IDLE is ignored, including a start in the same cycle as the DONE-state i_result_ready. A new run needs i_start in IDLE, one cycle later at the earliest.
- Products presented outside ACCUM are not accepted, since ready is low.
- o_term_cnt holds its final value through DONE and IDLE until the next start.

Optional Feature:
- Macro: MATH_ACC_SATURATE_EN.
- Defined: on any carry-out, acc clamps to all ones (2^ACC_W-1) and stays clamped for the rest of the run; o_overflow is set.
- Undefined: acc wraps modulo 2^ACC_W; o_overflow is still set.

Test Plan:
All scenarios use N=4, ACC_W=16, CNT_W=8.
- Reset mid-run: start count=5, accept 2 products, pulse i_rst_n low -> all outputs 0, state IDLE, no o_result_valid. A following run of 1 x 0x09 returns 0x0009.
- Basic dot product: start count=4, products 0x06, 0x0F, 0xE1, 0x01 back-to-back, i_result_ready=1 -> o_result_valid high exactly 1 cycle after the 4th handshake, o_result=0x00F7, o_term_cnt=4, o_overflow=0.
- Bubbles and backpressure: count=3, valid gapped 2 cycles between terms (0x10, 0x20, 0x30), i_result_ready held low 5 cycles -> o_result=0x0060 stable and valid for all 5 cycles, then IDLE one cycle after ready=1.
- Zero count: start count=0 -> o_result_valid next cycle with o_result=0, o_prod_ready never asserted, o_term_cnt=0.
- Overflow: count=255, all products 0xE1 (sum 57375), then a second run with count=2 and 0xFF each (510) -> no overflow on the first run. Set ACC_W=10 and rerun the second case with count=5 (1275): without the macro, o_result=0x0FB and o_overflow=1; with MATH_ACC_SATURATE_EN, o_result=0x3FF and o_overflow=1.
- Ignored start: assert i_start with count=7 during ACCUM and again during DONE together with i_result_ready -> the current run completes unchanged and the block sits in IDLE with o_busy=0.
